// File: rtl/iob_pkg.sv
// Shared types and constants for the ping-pong I/O buffer.
package iob_pkg;

  // Page-swap handshake states.
  typedef enum logic [0:0] {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

  // Macro test/margin pin tie-offs.
  localparam logic [2:0] MACRO_EMA     = 3'b010;
  localparam logic [1:0] MACRO_EMAW    = 2'b00;
  localparam logic       MACRO_TEST_EN = 1'b0;
  localparam logic       MACRO_BIST_EN = 1'b0;

  // Number of address bits that select a macro row within one page.
  function automatic int unsigned row_sel_w(input int unsigned addr_w,
                                            input int unsigned bank_aw);
    return addr_w - bank_aw;
  endfunction

endpackage

// File: rtl/iob_bank_array.sv
// One page of SRAM: rows x columns of BANK_W-wide macros, two ports.
// Port A is byte-masked read/write, port B is full-word read/write.
// This body is the inferred-RAM model used for FPGA builds.
module iob_bank_array
  import iob_pkg::*;
#(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned BANK_AW = 10,
  parameter int unsigned BANK_W  = 64,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_a_en,
  input  logic                i_a_we,
  input  logic [DATA_W/8-1:0] i_a_be,
  input  logic [ADDR_W-1:0]   i_a_addr,
  input  logic [DATA_W-1:0]   i_a_wdata,
  output logic [DATA_W-1:0]   o_a_rdata,
  input  logic                i_b_en,
  input  logic                i_b_we,
  input  logic [ADDR_W-1:0]   i_b_addr,
  input  logic [DATA_W-1:0]   i_b_wdata,
  output logic [DATA_W-1:0]   o_b_rdata
);

  localparam int unsigned ROW_SEL_W = row_sel_w(ADDR_W, BANK_AW);
  localparam int unsigned RS_W      = (ROW_SEL_W == 0) ? 1 : ROW_SEL_W;
  localparam int unsigned ROWS      = 1 << ROW_SEL_W;
  localparam int unsigned COLS      = DATA_W / BANK_W;
  localparam int unsigned DEPTH     = 1 << BANK_AW;

  logic [RS_W-1:0]             a_row, b_row;
  logic [BANK_AW-1:0]          a_baddr, b_baddr;
  logic [ROWS-1:0]             a_ce, b_ce;
  logic                        a_rd, b_rd;
  logic [DATA_W-1:0]           a_bmask;
  logic [ROWS-1:0][DATA_W-1:0] a_q, b_q;
  logic [RS_W-1:0]             a_rs_q, b_rs_q;

  assign a_row   = RS_W'(i_a_addr >> BANK_AW);
  assign b_row   = RS_W'(i_b_addr >> BANK_AW);
  assign a_baddr = i_a_addr[BANK_AW-1:0];
  assign b_baddr = i_b_addr[BANK_AW-1:0];
  assign a_rd    = i_a_en & ~i_a_we;
  assign b_rd    = i_b_en & ~i_b_we;

  // Expand port A byte enables to a bit mask.
  always_comb begin
    a_bmask = '0;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      a_bmask[i*8 +: 8] = {8{i_a_be[i]}};
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign a_ce[r] = i_a_en & (a_row == RS_W'(r));
    assign b_ce[r] = i_b_en & (b_row == RS_W'(r));

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [BANK_W-1:0] mem [DEPTH];
      logic [BANK_W-1:0] a_m, a_w, b_w, a_base;
      logic [BANK_W-1:0] qa_q, qb_q;

      assign a_m = a_bmask[c*BANK_W +: BANK_W];
      assign a_w = i_a_wdata[c*BANK_W +: BANK_W];
      assign b_w = i_b_wdata[c*BANK_W +: BANK_W];
      // Unmasked bytes of a colliding port A write keep port B's word.
      assign a_base = (b_ce[r] && i_b_we && (b_baddr == a_baddr)) ? b_w : mem[a_baddr];

      // Macro write ports; port A is applied last so it wins a collision.
      always_ff @(posedge i_clk) begin
        if (b_ce[r] && i_b_we) mem[b_baddr] <= b_w;
        if (a_ce[r] && i_a_we) mem[a_baddr] <= (a_base & ~a_m) | (a_w & a_m);
      end

      // Macro read outputs; hold until the next read of this macro.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          qa_q <= '0;
          qb_q <= '0;
        end else begin
          if (a_ce[r] && !i_a_we) qa_q <= mem[a_baddr];
          if (b_ce[r] && !i_b_we) qb_q <= mem[b_baddr];
        end
      end

      assign a_q[r][c*BANK_W +: BANK_W] = qa_q;
      assign b_q[r][c*BANK_W +: BANK_W] = qb_q;
    end
  end

  // Row select captured at read issue, steering the output mux.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_rs_q <= '0;
      b_rs_q <= '0;
    end else begin
      if (a_rd) a_rs_q <= a_row;
      if (b_rd) b_rs_q <= b_row;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              a_v_q, b_v_q;
    logic [DATA_W-1:0] a_o_q, b_o_q;

    // Extra output register stage, loaded one cycle after a read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        a_v_q <= 1'b0;
        b_v_q <= 1'b0;
        a_o_q <= '0;
        b_o_q <= '0;
      end else begin
        a_v_q <= a_rd;
        b_v_q <= b_rd;
        if (a_v_q) a_o_q <= a_q[a_rs_q];
        if (b_v_q) b_o_q <= b_q[b_rs_q];
      end
    end

    assign o_a_rdata = a_o_q;
    assign o_b_rdata = b_o_q;
  end else begin : g_lat1
    assign o_a_rdata = a_q[a_rs_q];
    assign o_b_rdata = b_q[b_rs_q];
  end

endmodule

// File: rtl/iob_pingpong_buffer.sv
// Double-buffered NPU I/O buffer: host port A and compute port B each own
// one page; a quiescent handshake exchanges the pages.
module iob_pingpong_buffer
  import iob_pkg::*;
#(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned BANK_AW = 10,
  parameter int unsigned BANK_W  = 64,
  parameter bit          PP_EN   = 1'b1,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ext_en,
  input  logic                i_ext_we,
  input  logic [DATA_W/8-1:0] i_ext_be,
  input  logic [ADDR_W-1:0]   i_ext_addr,
  input  logic [DATA_W-1:0]   i_ext_wdata,
  output logic [DATA_W-1:0]   o_ext_rdata,
  output logic                o_ext_rvld,
  input  logic                i_int_rd_en,
  input  logic                i_int_pad_en,
  input  logic                i_int_wr_en,
  input  logic [ADDR_W-1:0]   i_int_addr,
  input  logic [DATA_W-1:0]   i_int_wdata,
  output logic [DATA_W-1:0]   o_int_rdata,
  output logic                o_int_rvld,
  output logic                o_int_err,
  input  logic                i_swap_req,
  output logic                o_swap_pend,
  output logic                o_swap_done,
  output logic                o_ext_page
);

  localparam int unsigned NPAGE = PP_EN ? 2 : 1;

  swap_state_e state_q, state_d;
  logic        page_q, page_d;
  logic        arm_q, arm_d;
  logic        done_q, done_d;
  logic        err_q;

  logic [RD_LAT-1:0] a_vld_q, a_pg_q;
  logic [RD_LAT-1:0] b_vld_q, b_pg_q, b_pad_q;

  logic a_pg, b_pg;
  logic a_rd, b_wr, b_pad, b_rd, b_ram_en;
  logic any_en, pipe_busy, quiet;

  logic [1:0][DATA_W-1:0] pg_a_rdata, pg_b_rdata;

  assign a_pg = PP_EN ? page_q  : 1'b0;
  assign b_pg = PP_EN ? ~page_q : 1'b0;

  // Port B priority: write, then pad, then read.
  assign a_rd     = i_ext_en & ~i_ext_we;
  assign b_wr     = i_int_wr_en;
  assign b_pad    = ~i_int_wr_en & i_int_pad_en;
  assign b_rd     = ~i_int_wr_en & ~i_int_pad_en & i_int_rd_en;
  assign b_ram_en = b_wr | b_rd;

  for (genvar p = 0; p < NPAGE; p++) begin : g_page
    iob_bank_array #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BANK_AW (BANK_AW),
      .BANK_W  (BANK_W),
      .RD_LAT  (RD_LAT)
    ) u_bank (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_a_en    (i_ext_en & (a_pg == 1'(p))),
      .i_a_we    (i_ext_we),
      .i_a_be    (i_ext_be),
      .i_a_addr  (i_ext_addr),
      .i_a_wdata (i_ext_wdata),
      .o_a_rdata (pg_a_rdata[p]),
      .i_b_en    (b_ram_en & (b_pg == 1'(p))),
      .i_b_we    (b_wr),
      .i_b_addr  (i_int_addr),
      .i_b_wdata (i_int_wdata),
      .o_b_rdata (pg_b_rdata[p])
    );
  end

  if (!PP_EN) begin : g_no_page1
    assign pg_a_rdata[1] = '0;
    assign pg_b_rdata[1] = '0;
  end

  // Read/pad valid pipelines with the page each beat was issued against.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_vld_q <= '0;
      a_pg_q  <= '0;
      b_vld_q <= '0;
      b_pg_q  <= '0;
      b_pad_q <= '0;
    end else begin
      a_vld_q[0] <= a_rd;
      b_vld_q[0] <= b_pad | b_rd;
      b_pad_q[0] <= b_pad;
      if (a_rd) a_pg_q[0] <= a_pg;
      if (b_rd) b_pg_q[0] <= b_pg;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        a_vld_q[i] <= a_vld_q[i-1];
        b_vld_q[i] <= b_vld_q[i-1];
        b_pad_q[i] <= b_pad_q[i-1];
        if (a_vld_q[i-1]) a_pg_q[i] <= a_pg_q[i-1];
        if (b_vld_q[i-1]) b_pg_q[i] <= b_pg_q[i-1];
      end
    end
  end

  assign o_ext_rvld  = a_vld_q[RD_LAT-1];
  assign o_ext_rdata = pg_a_rdata[a_pg_q[RD_LAT-1]];
  assign o_int_rvld  = b_vld_q[RD_LAT-1];
  assign o_int_rdata = (b_vld_q[RD_LAT-1] && !b_pad_q[RD_LAT-1])
                     ? pg_b_rdata[b_pg_q[RD_LAT-1]] : '0;

  assign any_en    = i_ext_en | i_int_rd_en | i_int_pad_en | i_int_wr_en;
  assign pipe_busy = (|a_vld_q) | (|b_vld_q);
  assign quiet     = ~any_en & ~pipe_busy;

  // Swap next-state: arm on request low, execute on the first quiet cycle.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    done_d  = 1'b0;
    arm_d   = i_swap_req ? arm_q : 1'b1;
    unique case (state_q)
      SWAP_IDLE: begin
        if (PP_EN && i_swap_req && arm_q) state_d = SWAP_PEND;
      end
      SWAP_PEND: begin
        if (quiet) begin
          state_d = SWAP_IDLE;
          page_d  = ~page_q;
          done_d  = 1'b1;
          arm_d   = 1'b0;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Swap state, page ownership and port B conflict flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SWAP_IDLE;
      page_q  <= 1'b0;
      arm_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      arm_q   <= arm_d;
      done_q  <= done_d;
      err_q   <= i_int_wr_en & (i_int_rd_en | i_int_pad_en);
    end
  end

  assign o_swap_pend = (state_q == SWAP_PEND);
  assign o_swap_done = done_q;
  assign o_ext_page  = page_q;
  assign o_int_err   = err_q;

endmodule

// File: tb/tb_iob_pingpong_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-scheduled behavioural model of the two-page buffer.
module tb_iob_pingpong_buffer;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned BANK_AW = 10;
  localparam int unsigned BANK_W  = 64;
  localparam int          RD_LAT  = 2;
  localparam int unsigned BE_W    = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_ext_en = 1'b0, i_ext_we = 1'b0;
  logic [BE_W-1:0]   i_ext_be = '0;
  logic [ADDR_W-1:0] i_ext_addr = '0;
  logic [DATA_W-1:0] i_ext_wdata = '0;
  logic              i_int_rd_en = 1'b0, i_int_pad_en = 1'b0, i_int_wr_en = 1'b0;
  logic [ADDR_W-1:0] i_int_addr = '0;
  logic [DATA_W-1:0] i_int_wdata = '0;
  logic              i_swap_req = 1'b0;
  logic [DATA_W-1:0] o_ext_rdata, o_int_rdata;
  logic              o_ext_rvld, o_int_rvld, o_int_err;
  logic              o_swap_pend, o_swap_done, o_ext_page;

  iob_pingpong_buffer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BANK_AW (BANK_AW),
    .BANK_W  (BANK_W),
    .PP_EN   (1'b1),
    .RD_LAT  (RD_LAT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ext_en     (i_ext_en),
    .i_ext_we     (i_ext_we),
    .i_ext_be     (i_ext_be),
    .i_ext_addr   (i_ext_addr),
    .i_ext_wdata  (i_ext_wdata),
    .o_ext_rdata  (o_ext_rdata),
    .o_ext_rvld   (o_ext_rvld),
    .i_int_rd_en  (i_int_rd_en),
    .i_int_pad_en (i_int_pad_en),
    .i_int_wr_en  (i_int_wr_en),
    .i_int_addr   (i_int_addr),
    .i_int_wdata  (i_int_wdata),
    .o_int_rdata  (o_int_rdata),
    .o_int_rvld   (o_int_rvld),
    .o_int_err    (o_int_err),
    .i_swap_req   (i_swap_req),
    .o_swap_pend  (o_swap_pend),
    .o_swap_done  (o_swap_done),
    .o_ext_page   (o_ext_page)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [int];   // key = page*2^ADDR_W + addr
  logic [DATA_W-1:0] s_a [int];     // port A data due in a given cycle
  logic [DATA_W-1:0] s_b [int];     // port B data due in a given cycle
  int   cyc = 0;
  int   last_rd = -100;
  int   m_page = 0;
  bit   m_pend = 0, m_armed = 1, e_err = 0, e_done = 0;
  logic [DATA_W-1:0] e_ext_rdata = '0;

  logic [ADDR_W-1:0] pool [9] = '{12'h000, 12'h010, 12'h020, 12'h3FF, 12'h400,
                                  12'h7FF, 12'h800, 12'hC01, 12'hFFF};

  function automatic int mkey(input int pg, input logic [ADDR_W-1:0] a);
    return pg * (1 << ADDR_W) + int'(a);
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input int pg, input logic [ADDR_W-1:0] a);
    return m_mem.exists(mkey(pg, a)) ? m_mem[mkey(pg, a)] : 'x;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < int'(DATA_W / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Apply the rules for the clock edge that ends the current cycle.
  task automatic model_edge();
    int pa, pb;
    bit busy, any_en, a_rdv, b_padv, b_rdv;
    logic [DATA_W-1:0] w;
    pa     = m_page;
    pb     = 1 - m_page;
    busy   = (cyc - last_rd) <= RD_LAT;
    any_en = i_ext_en | i_int_rd_en | i_int_pad_en | i_int_wr_en;
    a_rdv  = i_ext_en & ~i_ext_we;
    b_padv = ~i_int_wr_en & i_int_pad_en;
    b_rdv  = ~i_int_wr_en & ~i_int_pad_en & i_int_rd_en;
    if (a_rdv) s_a[cyc + RD_LAT] = m_read(pa, i_ext_addr);
    if (b_padv) s_b[cyc + RD_LAT] = '0;
    else if (b_rdv) s_b[cyc + RD_LAT] = m_read(pb, i_int_addr);
    if (a_rdv || b_padv || b_rdv) last_rd = cyc;
    e_err = i_int_wr_en & (i_int_rd_en | i_int_pad_en);
    if (i_int_wr_en) m_mem[mkey(pb, i_int_addr)] = i_int_wdata;
    if (i_ext_en && i_ext_we && (i_ext_be != '0)) begin
      w = m_read(pa, i_ext_addr);
      for (int i = 0; i < int'(BE_W); i++)
        if (i_ext_be[i]) w[i*8 +: 8] = i_ext_wdata[i*8 +: 8];
      m_mem[mkey(pa, i_ext_addr)] = w;
    end
    e_done = 0;
    if (m_pend && !any_en && !busy) begin
      m_page  = 1 - m_page;
      m_pend  = 0;
      e_done  = 1;
    end else if (!m_pend && i_swap_req && m_armed) begin
      m_pend = 1;
    end
    if (e_done) m_armed = 0;
    else if (!i_swap_req) m_armed = 1;
  endtask

  task automatic check_outputs();
    bit ea_v, eb_v;
    logic [DATA_W-1:0] eb_d;
    ea_v = s_a.exists(cyc);
    if (ea_v) begin
      e_ext_rdata = s_a[cyc];
      s_a.delete(cyc);
    end
    eb_v = s_b.exists(cyc);
    eb_d = eb_v ? s_b[cyc] : '0;
    if (eb_v) s_b.delete(cyc);
    check_eq("ext_rvld", o_ext_rvld, ea_v);
    check_eq("ext_rdata", o_ext_rdata, e_ext_rdata);
    check_eq("int_rvld", o_int_rvld, eb_v);
    check_eq("int_rdata", o_int_rdata, eb_d);
    check_eq("int_err", o_int_err, e_err);
    check_eq("swap_pend", o_swap_pend, m_pend);
    check_eq("swap_done", o_swap_done, e_done);
    check_eq("ext_page", o_ext_page, m_page[0]);
  endtask

  task automatic step();
    model_edge();
    @(posedge i_clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic set_idle();
    i_ext_en = 0; i_ext_we = 0; i_ext_be = '0;
    i_int_rd_en = 0; i_int_pad_en = 0; i_int_wr_en = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ext_rdata"}, o_ext_rdata, '0);
    check_eq({tag, "_ext_rvld"}, o_ext_rvld, 0);
    check_eq({tag, "_int_rdata"}, o_int_rdata, '0);
    check_eq({tag, "_int_rvld"}, o_int_rvld, 0);
    check_eq({tag, "_int_err"}, o_int_err, 0);
    check_eq({tag, "_swap_pend"}, o_swap_pend, 0);
    check_eq({tag, "_swap_done"}, o_swap_done, 0);
    check_eq({tag, "_ext_page"}, o_ext_page, 0);
  endtask

  // Asynchronous reset mid-cycle; RAM model contents survive.
  task automatic apply_reset();
    set_idle();
    i_swap_req = 0;
    #2 i_rst_n = 0;
    #1;
    check_reset_outputs("rst");
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst_n = 1;
    s_a.delete();
    s_b.delete();
    last_rd = -100; m_page = 0; m_pend = 0; m_armed = 1;
    e_err = 0; e_done = 0; e_ext_rdata = '0;
  endtask

  initial begin
    logic [DATA_W-1:0] w, exp;
    int np, nd;

    #1;
    check_reset_outputs("por");
    #22 i_rst_n = 1;

    // Fill the address pool on both pages (A -> page 0, B -> page 1).
    for (int i = 0; i < 9; i++) begin
      set_idle();
      i_ext_en = 1; i_ext_we = 1; i_ext_be = '1; i_ext_addr = pool[i]; i_ext_wdata = rand_word();
      i_int_wr_en = 1; i_int_addr = pool[i]; i_int_wdata = rand_word();
      step();
    end
    set_idle();
    step();

    // A writes A5.. at 0x010 on page 0, swap, B reads it back.
    i_ext_en = 1; i_ext_we = 1; i_ext_be = '1; i_ext_addr = 12'h010;
    i_ext_wdata = {(DATA_W/8){8'hA5}};
    step();
    set_idle();
    i_swap_req = 1;
    repeat (4) step();
    i_swap_req = 0;
    step();
    check_eq("tp1_page", o_ext_page, 1);
    i_int_rd_en = 1; i_int_addr = 12'h010;
    step();
    set_idle();
    repeat (RD_LAT - 1) step();
    check_eq("tp1_rvld", o_int_rvld, 1);
    check_eq("tp1_data", o_int_rdata, {(DATA_W/8){8'hA5}});
    step();

    // Byte-enabled write over an all-ones word.
    i_ext_en = 1; i_ext_we = 1; i_ext_be = '1; i_ext_addr = 12'h020; i_ext_wdata = '1;
    step();
    i_ext_be = BE_W'(32'h0000_000F); i_ext_wdata = {(DATA_W/32){32'hDEAD_BEEF}};
    step();
    i_ext_we = 0; i_ext_be = '0;
    step();
    set_idle();
    repeat (RD_LAT - 1) step();
    exp = '1;
    exp[31:0] = 32'hDEAD_BEEF;
    check_eq("tp2_rvld", o_ext_rvld, 1);
    check_eq("tp2_data", o_ext_rdata, exp);
    step();

    // Pad read returns zero regardless of write data.
    i_int_pad_en = 1; i_int_addr = 12'h3FF; i_int_wdata = DATA_W'(16'h1234);
    step();
    set_idle();
    repeat (RD_LAT - 1) step();
    check_eq("tp3_rvld", o_int_rvld, 1);
    check_eq("tp3_data", o_int_rdata, '0);
    step();

    // Reset while PEND with a read in flight (page currently 1).
    i_swap_req = 1; i_int_rd_en = 1; i_int_addr = 12'h7FF;
    step();
    check_eq("tp6_pend", o_swap_pend, 1);
    apply_reset();
    repeat (RD_LAT + 2) step();
    check_eq("tp6_no_stray_rvld", o_int_rvld, 0);
    check_eq("tp6_page", o_ext_page, 0);

    // Swap held off by five back-to-back reads, exactly one pulse.
    i_swap_req = 1; np = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      i_int_rd_en = 1; i_int_addr = pool[$urandom_range(8, 0)];
      step();
      if (o_swap_pend) np++;
      if (o_swap_done) nd++;
    end
    set_idle();
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_swap_done) nd++;
    end
    check_eq("tp4_pend_during_reads", np, 5);
    check_eq("tp4_done_pulses", nd, 1);
    check_eq("tp4_page", o_ext_page, 1);
    i_swap_req = 0;
    step();

    // Write with conflicting read at row 2: write lands, error pulse.
    w = rand_word();
    i_int_wr_en = 1; i_int_rd_en = 1; i_int_addr = 12'h800; i_int_wdata = w;
    step();
    check_eq("tp5_err", o_int_err, 1);
    set_idle();
    step();
    check_eq("tp5_err_pulse", o_int_err, 0);
    repeat (RD_LAT) step();
    i_int_rd_en = 1; i_int_addr = 12'h800;
    step();
    set_idle();
    repeat (RD_LAT - 1) step();
    check_eq("tp5_rvld", o_int_rvld, 1);
    check_eq("tp5_data", o_int_rdata, w);
    step();

    // Random traffic with periodic quiet windows so swaps can execute.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      if ($urandom_range(7, 0) == 0) i_swap_req = ~i_swap_req;
      if ((i % 24) < 18) begin
        i_ext_en    = $urandom_range(1, 0) == 1;
        i_ext_we    = $urandom_range(1, 0) == 1;
        i_ext_be    = ($urandom_range(3, 0) == 0) ? '1 : BE_W'(rand_word());
        i_ext_addr  = pool[$urandom_range(8, 0)];
        i_ext_wdata = rand_word();
        i_int_wr_en  = $urandom_range(6, 0) == 0;
        i_int_pad_en = $urandom_range(6, 0) == 0;
        i_int_rd_en  = $urandom_range(2, 0) == 0;
        i_int_addr   = pool[$urandom_range(8, 0)];
        i_int_wdata  = rand_word();
      end
      step();
    end
    set_idle();
    i_swap_req = 0;
    repeat (RD_LAT + 2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
